// File: rtl/pll_loop_filter_iir.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_loop_filter_iir: 2nd-order IIR PLL loop filter, 3-cycle pipeline  |
// | with shadow coefficients, saturation and hold/reinit. Rev 1.0        |
// +----------------------------------------------------------------------+
module pll_loop_filter_iir #(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int COEF_FRAC  = 12,
  parameter int STATE_FRAC = 16,
  parameter int YINIT_RST  = 0,
  parameter int A0_RST     = 0,
  parameter int A1_RST     = 0,
  parameter int B1_RST     = 0,
  parameter int B2_RST     = 0
) (
  input  logic                     clock,
  input  logic                     arst,
  input  logic signed [DATA_W-1:0] xin,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] yout,
  output logic                     out_valid,
  input  logic                     cfg_wr,
  input  logic [2:0]               cfg_addr,
  input  logic [COEF_W-1:0]        cfg_data,
  input  logic                     cfg_commit,
  output logic                     commit_pending,
  input  logic                     hold,
  input  logic                     reinit,
  output logic                     sat,
  input  logic                     sat_clr
);

  localparam int SW   = DATA_W + STATE_FRAC;
  localparam int TW   = COEF_W + SW + 3;
  localparam int A_SH = STATE_FRAC - COEF_FRAC;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;

  localparam logic signed [SW-1:0] c_ymax = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] c_ymin = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [TW-1:0] c_tmax = {{(TW-SW){1'b0}}, c_ymax};
  localparam logic signed [TW-1:0] c_tmin = {{(TW-SW){1'b1}}, c_ymin};

  localparam logic signed [DATA_W-1:0] c_yinit_rst = DATA_W'(YINIT_RST);
  localparam logic signed [SW-1:0]     c_y_rst     = {c_yinit_rst, {STATE_FRAC{1'b0}}};
  localparam logic signed [COEF_W-1:0] c_coef_rst [4] =
    '{COEF_W'(A0_RST), COEF_W'(A1_RST), COEF_W'(B1_RST), COEF_W'(B2_RST)};

  logic [1:0]               r_state;
  logic signed [COEF_W-1:0] r_coef   [4];
  logic signed [COEF_W-1:0] r_shadow [4];
  logic signed [DATA_W-1:0] r_yinit, r_syinit;
  logic signed [DATA_W-1:0] r_xs, r_x1;
  logic signed [SW-1:0]     r_y1, r_y2;
  logic signed [TW-1:0]     r_t0, r_t1, r_t2, r_t3;
  logic                     r_out_valid, r_sat, r_pend;

  logic                     w_idle, w_commit_now, w_reinit_now, w_accept;
  logic signed [DATA_W-1:0] w_cfg_y;
  logic signed [TW-1:0]     w_p0, w_p1, w_p2, w_p3, w_sum;
  logic                     w_hi, w_lo;
  logic signed [SW-1:0]     w_ynext;

  function automatic logic signed [TW-1:0] sx_c(input logic signed [COEF_W-1:0] v);
    return {{(TW-COEF_W){v[COEF_W-1]}}, v};
  endfunction

  function automatic logic signed [TW-1:0] sx_d(input logic signed [DATA_W-1:0] v);
    return {{(TW-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [TW-1:0] sx_s(input logic signed [SW-1:0] v);
    return {{(TW-SW){v[SW-1]}}, v};
  endfunction

  generate
    if (DATA_W <= COEF_W) begin : g_yinit_trunc
      assign w_cfg_y = cfg_data[DATA_W-1:0];
    end else begin : g_yinit_sext
      assign w_cfg_y = {{(DATA_W-COEF_W){cfg_data[COEF_W-1]}}, cfg_data};
    end
  endgenerate

  assign w_idle       = (r_state == ST_IDLE);
  assign w_commit_now = w_idle && r_pend;
  assign in_ready     = w_idle && !hold && !r_pend;
  assign w_reinit_now = w_idle && !hold && reinit;
  // reinit takes priority: a sample offered alongside it is dropped
  assign w_accept     = in_valid && in_ready && !reinit;

  // All terms aligned to STATE_FRAC fractional bits before the sum
  assign w_p0 = (sx_c(r_coef[0]) * sx_d(r_xs)) <<< A_SH;
  assign w_p1 = (sx_c(r_coef[1]) * sx_d(r_x1)) <<< A_SH;
  assign w_p2 = (sx_c(r_coef[2]) * sx_s(r_y1)) >>> COEF_FRAC;
  assign w_p3 = (sx_c(r_coef[3]) * sx_s(r_y2)) >>> COEF_FRAC;

  assign w_sum   = r_t0 + r_t1 + r_t2 + r_t3;
  assign w_hi    = (w_sum > c_tmax);
  assign w_lo    = (w_sum < c_tmin);
  assign w_ynext = w_hi ? c_ymax : (w_lo ? c_ymin : w_sum[SW-1:0]);

  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        r_coef[i]   <= c_coef_rst[i];
        r_shadow[i] <= c_coef_rst[i];
      end
      r_yinit     <= c_yinit_rst;
      r_syinit    <= c_yinit_rst;
      r_xs        <= '0;
      r_x1        <= '0;
      r_y1        <= c_y_rst;
      r_y2        <= c_y_rst;
      r_t0        <= '0;
      r_t1        <= '0;
      r_t2        <= '0;
      r_t3        <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      // The copy reads pre-write shadow values when a write lands on the same edge
      if (w_commit_now) begin
        r_coef  <= r_shadow;
        r_yinit <= r_syinit;
      end
      if (cfg_wr) begin
        if (cfg_addr == 3'd4) r_syinit <= w_cfg_y;
        else if (!cfg_addr[2]) r_shadow[cfg_addr[1:0]] <= cfg_data;
      end
      r_pend <= cfg_commit || (r_pend && !w_commit_now);
      if (sat_clr) r_sat <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_reinit_now) begin
            r_y1 <= {r_yinit, {STATE_FRAC{1'b0}}};
            r_y2 <= {r_yinit, {STATE_FRAC{1'b0}}};
            r_x1 <= '0;
          end else if (w_accept) begin
            r_xs    <= xin;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_t0    <= w_p0;
          r_t1    <= w_p1;
          r_t2    <= w_p2;
          r_t3    <= w_p3;
          r_x1    <= r_xs;
          r_state <= ST_ACC;
        end
        ST_ACC: begin
          r_y2        <= r_y1;
          r_y1        <= w_ynext;
          // Set after the clear so a coincident saturation wins
          if (w_hi || w_lo) r_sat <= 1'b1;
          r_out_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign yout           = r_y1[SW-1:STATE_FRAC];
  assign out_valid      = r_out_valid;
  assign sat            = r_sat;
  assign commit_pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_pll_loop_filter_iir.sv
`default_nettype none
// Directed bench for pll_loop_filter_iir: vector table plus hand-written
// sequences for throughput, saturation, commit timing, reinit/hold and reset.
module tb_pll_loop_filter_iir;

  logic               clock = 1'b0;
  logic               arst;
  logic signed [15:0] xin;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] yout;
  logic               out_valid;
  logic               cfg_wr;
  logic [2:0]         cfg_addr;
  logic [15:0]        cfg_data;
  logic               cfg_commit;
  logic               commit_pending;
  logic               hold;
  logic               reinit;
  logic               sat;
  logic               sat_clr;

  int n_tests = 0;
  int n_fail  = 0;

  pll_loop_filter_iir dut (
    .clock          (clock),
    .arst           (arst),
    .xin            (xin),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .yout           (yout),
    .out_valid      (out_valid),
    .cfg_wr         (cfg_wr),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .commit_pending (commit_pending),
    .hold           (hold),
    .reinit         (reinit),
    .sat            (sat),
    .sat_clr        (sat_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit cfg;
    int a0, a1, b1, b2;
    int x;
    int y;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Load all four coefficients, commit, then reinit the state to yinit
  task automatic do_cfg(input int a0, input int a1, input int b1, input int b2);
    int c [4];
    c[0] = a0; c[1] = a1; c[2] = b1; c[3] = b2;
    for (int k = 0; k < 4; k++) begin
      cfg_wr   = 1'b1;
      cfg_addr = 3'(k);
      cfg_data = c[k][15:0];
      tick();
    end
    cfg_wr     = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    chk("commit_clear", commit_pending, 0);
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
  endtask

  // Offer one sample, wait for acceptance, run to the out_valid cycle
  task automatic send(input int x, input bit clr_in_acc);
    int n;
    n        = 0;
    xin      = x[15:0];
    in_valid = 1'b1;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("ov_early", out_valid, 0);
    if (clr_in_acc) sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
  endtask

  initial begin
    bit seen_ov;

    vecs[0]  = '{1, 4096, 0, 0, 0, 100, 100};
    vecs[1]  = '{0, 0, 0, 0, 0, -7, -7};
    vecs[2]  = '{1, 4096, 0, 4096, 0, 10, 10};
    vecs[3]  = '{0, 0, 0, 0, 0, 10, 20};
    vecs[4]  = '{0, 0, 0, 0, 0, 10, 30};
    vecs[5]  = '{1, 2048, 0, 0, 0, -3, -2};
    vecs[6]  = '{0, 0, 0, 0, 0, 3, 1};
    vecs[7]  = '{1, 0, 4096, 0, 0, 5, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 9, 5};
    vecs[9]  = '{1, 4096, 0, 0, 4096, 1, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 1, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 1, 2};
    vecs[12] = '{1, 4096, 0, -2048, 0, 10, 10};
    vecs[13] = '{0, 0, 0, 0, 0, 0, -5};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 2};

    arst = 1'b1; xin = '0; in_valid = 1'b0; cfg_wr = 1'b0; cfg_addr = '0;
    cfg_data = '0; cfg_commit = 1'b0; hold = 1'b0; reinit = 1'b0; sat_clr = 1'b0;
    #1;
    chk("rst_yout", yout, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_sat", sat, 0);
    chk("rst_pend", commit_pending, 0);
    tick();
    tick();
    arst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].cfg) do_cfg(vecs[i].a0, vecs[i].a1, vecs[i].b1, vecs[i].b2);
      send(vecs[i].x, 1'b0);
      chk($sformatf("vec%0d_ov", i), out_valid, 1);
      chk($sformatf("vec%0d_y", i), yout, vecs[i].y);
      chk($sformatf("vec%0d_sat", i), sat, 0);
    end

    // Integrator with in_valid held high: one acceptance every third cycle
    do_cfg(4096, 0, 4096, 0);
    xin = 16'sd10;
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("thru_ready%0d", i), in_ready, (i % 3 == 0) ? 1 : 0);
      tick();
      chk($sformatf("thru_ov%0d", i), out_valid, (i % 3 == 2) ? 1 : 0);
      if (i % 3 == 2) chk($sformatf("thru_y%0d", i), yout, 10 * (i / 3 + 1));
    end
    in_valid = 1'b0;
    tick();

    // Positive saturation, clear racing a new saturation, then plain clear
    do_cfg(4096, 0, 4096, 0);
    send(32767, 1'b0);
    chk("satp1_y", yout, 32767);
    chk("satp1_sat", sat, 0);
    send(32767, 1'b0);
    chk("satp2_y", yout, 32767);
    chk("satp2_sat", sat, 1);
    send(32767, 1'b1);
    chk("satp3_sat_wins", sat, 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clr", sat, 0);

    do_cfg(4096, 0, 4096, 0);
    send(-32768, 1'b0);
    chk("satn1_y", yout, -32768);
    chk("satn1_sat", sat, 0);
    send(-32768, 1'b0);
    chk("satn2_y", yout, -32768);
    chk("satn2_sat", sat, 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;

    // Commit raised while a sample is in MUL must not affect that sample
    do_cfg(4096, 0, 4096, 0);
    send(10, 1'b0);
    chk("cm_y0", yout, 10);
    cfg_wr = 1'b1; cfg_addr = 3'd0; cfg_data = 16'd8192;
    xin = 16'sd10; in_valid = 1'b1;
    tick();
    cfg_wr = 1'b0; in_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("cm_pend_set", commit_pending, 1);
    tick();
    chk("cm_ov", out_valid, 1);
    chk("cm_y_old_coef", yout, 20);
    chk("cm_ready_blocked", in_ready, 0);
    chk("cm_pend_still", commit_pending, 1);
    tick();
    chk("cm_pend_clr", commit_pending, 0);
    chk("cm_ready", in_ready, 1);
    send(10, 1'b0);
    chk("cm_y_new_coef", yout, 40);

    // yinit commit leaves state alone; reinit applies it without out_valid
    cfg_wr = 1'b1; cfg_addr = 3'd4; cfg_data = 16'd500;
    tick();
    cfg_wr = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    chk("yi_commit_nochange", yout, 40);
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    chk("yi_reinit_y", yout, 500);
    chk("yi_reinit_ov", out_valid, 0);

    xin = 16'sd77; in_valid = 1'b1; reinit = 1'b1;
    tick();
    reinit = 1'b0; in_valid = 1'b0;
    seen_ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    chk("ri_drop_ov", seen_ov, 0);
    chk("ri_drop_y", yout, 500);

    hold = 1'b1; xin = 16'sd100; in_valid = 1'b1;
    #1;
    chk("hold_ready", in_ready, 0);
    seen_ov = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    chk("hold_ov", seen_ov, 0);
    chk("hold_y", yout, 500);
    hold = 1'b0; in_valid = 1'b0;
    tick();

    // Asynchronous reset while the sample sits in ACC
    xin = 16'sd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    arst = 1'b1;
    #1;
    chk("arst_y", yout, 0);
    chk("arst_ov", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    seen_ov = 1'b0;
    tick();
    if (out_valid) seen_ov = 1'b1;
    arst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    chk("arst_no_ov", seen_ov, 0);
    send(100, 1'b0);
    chk("arst_coef_ov", out_valid, 1);
    chk("arst_coef_y", yout, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
